bin_to_bcd4: RTL and testbench

- Sequential binary-to-BCD converter that sits directly upstream of the 4-digit 7-segment display driver.
- Takes an unsigned binary value (0..9999) on a start strobe and converts it with iterative shift-add-3 (double dabble), one bit per clock.
- Presents the result as four BCD nibbles on `hexx` plus a digit `mask`; both are wired straight into the display driver's `hexx` and `mask` inputs.
- Out-of-range inputs produce an "EEEE" error pattern.

---
 rtl/bin_to_bcd4_pkg.sv | 26 ++
 rtl/bin_to_bcd4_add3.sv | 9 +
 rtl/bin_to_bcd4.sv | 132 +++++++++++++
 tb/tb_bin_to_bcd4.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd4_pkg.sv
// Shared types and constants for the bin_to_bcd4 double-dabble converter.
package bin_to_bcd4_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam int unsigned BCD_DIGITS        = 4;
    localparam int unsigned BCD_W             = 4 * BCD_DIGITS;
    localparam int unsigned DEFAULT_WIDTH     = 14;
    localparam int unsigned DEFAULT_MAX_VALUE = 9999;
    localparam logic [15:0] ERR_PATTERN       = 16'hEEEE;

    // Blank leading zero digits from D4 downward; D1 is always shown.
    function automatic logic [3:0] lead_zero_mask(input logic [11:0] upper_digits);
        logic [3:0] m;
        m    = 4'b0000;
        m[3] = (upper_digits[11:8] == 4'd0);
        m[2] = m[3] && (upper_digits[7:4] == 4'd0);
        m[1] = m[2] && (upper_digits[3:0] == 4'd0);
        return m;
    endfunction

endpackage

// File: rtl/bin_to_bcd4_add3.sv
// Double-dabble nibble corrector: adds 3 to any BCD digit of 5 or more.
module bcd_add3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib_c
);

    assign o_nib_c = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/bin_to_bcd4.sv
// Iterative binary-to-BCD converter feeding a 4-digit 7-segment driver.
// Optional leading-zero blanking of the digit mask: define LEADING_ZERO_BLANK_EN.
module bin_to_bcd4
    import bin_to_bcd4_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned MAX_VALUE = DEFAULT_MAX_VALUE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [15:0]      hexx,
    output logic [3:0]       mask,
    output logic             overflow
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] MASK_RST = 4'b1110;
`else
    localparam logic [3:0] MASK_RST = 4'b0000;
`endif

    state_t             r_state, w_state_n;
    logic [WIDTH-1:0]   r_bin, w_bin_n;
    logic [BCD_W-1:0]   r_bcd, w_bcd_n;
    logic [CNT_W-1:0]   r_cnt, w_cnt_n;
    logic               r_ovf_pend, w_ovf_pend_n;
    logic               r_busy, w_busy_n;
    logic               r_done, w_done_n;
    logic [15:0]        r_hexx, w_hexx_n;
    logic [3:0]         r_mask, w_mask_n;
    logic               r_ovf, w_ovf_n;
    logic [BCD_W-1:0]   w_adj;
    logic               w_bin_ovf;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_nib   (r_bcd[4*g +: 4]),
            .o_nib_c (w_adj[4*g +: 4])
        );
    end

    assign w_bin_ovf = 32'(bin) > MAX_VALUE;

    // Next-state and datapath update; a carry out of D4 also marks the result invalid.
    always_comb begin
        w_state_n    = r_state;
        w_bin_n      = r_bin;
        w_bcd_n      = r_bcd;
        w_cnt_n      = r_cnt;
        w_ovf_pend_n = r_ovf_pend;
        w_busy_n     = r_busy;
        w_done_n     = 1'b0;
        w_hexx_n     = r_hexx;
        w_mask_n     = r_mask;
        w_ovf_n      = r_ovf;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_n    = SHIFT;
                    w_bin_n      = bin;
                    w_bcd_n      = '0;
                    w_cnt_n      = '0;
                    w_ovf_pend_n = w_bin_ovf;
                    w_busy_n     = 1'b1;
                end
            end
            SHIFT: begin
                w_bcd_n      = {w_adj[BCD_W-2:0], r_bin[WIDTH-1]};
                w_bin_n      = {r_bin[WIDTH-2:0], 1'b0};
                w_cnt_n      = r_cnt + CNT_W'(1);
                w_ovf_pend_n = r_ovf_pend | w_adj[BCD_W-1];
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_state_n = UPDATE;
                end
            end
            UPDATE: begin
                w_state_n = IDLE;
                w_hexx_n  = r_ovf_pend ? ERR_PATTERN : r_bcd;
                w_ovf_n   = r_ovf_pend;
`ifdef LEADING_ZERO_BLANK_EN
                w_mask_n  = r_ovf_pend ? 4'b0000 : lead_zero_mask(r_bcd[BCD_W-1:4]);
`else
                w_mask_n  = 4'b0000;
`endif
                w_done_n  = 1'b1;
                w_busy_n  = 1'b0;
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_hexx     <= 16'h0000;
            r_mask     <= MASK_RST;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_bin      <= w_bin_n;
            r_bcd      <= w_bcd_n;
            r_cnt      <= w_cnt_n;
            r_ovf_pend <= w_ovf_pend_n;
            r_busy     <= w_busy_n;
            r_done     <= w_done_n;
            r_hexx     <= w_hexx_n;
            r_mask     <= w_mask_n;
            r_ovf      <= w_ovf_n;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign hexx     = r_hexx;
    assign mask     = r_mask;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd4.sv
// Scoreboard bench for bin_to_bcd4: decimal reference model, randomized and directed values.
module tb_bin_to_bcd4;

    localparam int unsigned W    = 14;
    localparam int unsigned MAXV = 9999;
    localparam int unsigned LAT  = W + 1;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] MASK_RST = 4'b1110;
`else
    localparam logic [3:0] MASK_RST = 4'b0000;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  bin;
    logic          busy;
    logic          done;
    logic [15:0]   hexx;
    logic [3:0]    mask;
    logic          overflow;

    typedef struct {
        logic [15:0] hexx;
        logic [3:0]  mask;
        logic        ovf;
        int unsigned cyc;
        int unsigned val;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;

    bin_to_bcd4 #(.WIDTH(W), .MAX_VALUE(MAXV)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .hexx     (hexx),
        .mask     (mask),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: decimal digits by division, blanking by magnitude.
    function automatic exp_t model(input int unsigned v, input int unsigned c);
        exp_t e;
        e.val = v;
        e.cyc = c;
        if (v > MAXV) begin
            e.hexx = 16'hEEEE;
            e.mask = 4'b0000;
            e.ovf  = 1'b1;
        end else begin
            e.hexx = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
            e.ovf  = 1'b0;
            e.mask = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
            if (v < 1000) e.mask[3] = 1'b1;
            if (v < 100)  e.mask[2] = 1'b1;
            if (v < 10)   e.mask[1] = 1'b1;
`endif
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = q.pop_front();
                check($sformatf("hexx[%0d]", mon_e.val), 32'(hexx), 32'(mon_e.hexx));
                check($sformatf("mask[%0d]", mon_e.val), 32'(mask), 32'(mon_e.mask));
                check($sformatf("overflow[%0d]", mon_e.val), 32'(overflow), 32'(mon_e.ovf));
                check($sformatf("done_cycle[%0d]", mon_e.val), cyc, mon_e.cyc);
                check("busy_low_at_done", 32'(busy), 32'd0);
            end
        end
    end

    // Called just after a negedge; returns the edge index at which start was taken.
    task automatic start_conv(input int unsigned v, input bit push, output int unsigned n);
        bin   = W'(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        n     = cyc;
        start = 1'b0;
        if (push) q.push_back(model(v, n + LAT));
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Wait until the scoreboard drains; optionally jiggle start/bin while the DUT is mid-conversion.
    task automatic wait_drain(input bit noise, input int unsigned n);
        int unsigned k;
        k = 0;
        while (q.size() != 0 && k < 200) begin
            @(negedge clk);
            #1;
            k++;
            if (noise && (cyc + 2 <= n + W)) begin
                start = 1'(($urandom % 2));
                bin   = W'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        if (q.size() != 0) begin
            check("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        int unsigned dir_vals[10] = '{1234, 0, 9999, 10000, 5, 1000, 305, 42, 7, 16383};
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_hexx", 32'(hexx), 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_mask", 32'(mask), 32'(MASK_RST));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;

        foreach (dir_vals[i]) begin
            start_conv(dir_vals[i], 1'b1, n);
            wait_drain(1'b0, n);
        end

        // start pulses and bin changes mid-conversion must be ignored
        repeat (3) begin
            start_conv($urandom_range(0, 2**W - 1), 1'b1, n);
            wait_drain(1'b1, n);
        end

        // start held high: a new conversion every W+2 cycles
        bin   = W'(42);
        start = 1'b1;
        @(posedge clk);
        #1;
        n = cyc;
        for (int i = 0; i < 3; i++) q.push_back(model(42, n + i * (W + 2) + LAT));
        repeat (2 * (W + 2)) @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain(1'b0, n);

        // reset mid-SHIFT aborts with no done pulse
        start_conv(777, 1'b0, n);
        repeat (5) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_hexx", 32'(hexx), 32'h0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_mask", 32'(mask), 32'(MASK_RST));
        check("midrst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 8) @(negedge clk);
        #1;
        check("midrst_still_idle", 32'(busy), 32'd0);

        for (int i = 0; i < 40; i++) begin
            int unsigned v;
            v = ($urandom % 4 == 0) ? $urandom_range(9990, 2**W - 1) : $urandom_range(0, MAXV);
            start_conv(v, 1'b1, n);
            wait_drain(1'($urandom % 2), n);
        end

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
